// File: rtl/bldc_pwm_bank.sv
// bldc_pwm_bank: shared-counter multi-phase PWM with double-buffered duties
// and per-phase dead-time insertion on every side change.
module bldc_pwm_bank #(
   parameter int NUM_PHASES     = 3,
   parameter int COUNTER_WIDTH  = 11,
   parameter int MAX_COUNTER    = 1000,
   parameter int DUTY_WIDTH     = 9,
   parameter int DUTY_SCALE     = 2,
   parameter int DEAD_TIME      = 4,
   parameter int CENTER_ALIGNED = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PHASES*DUTY_WIDTH-1:0] duty,
   input  logic                             duty_load,
   input  logic [NUM_PHASES-1:0]            high_z,
   output logic                             duty_pending,
   output logic                             period_start,
   output logic [NUM_PHASES-1:0]            pwm_high,
   output logic [NUM_PHASES-1:0]            pwm_low
);
   localparam int CW  = COUNTER_WIDTH;
   localparam int DW  = DUTY_WIDTH;
   localparam int PW  = CW + DW;
   localparam int NW  = NUM_PHASES * DW;
   localparam int DCW = DEAD_TIME > 1 ? $clog2(DEAD_TIME) : 1;
   localparam logic [CW-1:0] MAXC = CW'(MAX_COUNTER);
   typedef enum logic [1:0] {S_OFF, S_DEAD, S_HIGH, S_LOW} state_t;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          up_q, up_d, ps_q, pend_q, pend_d, wrap;
   logic [NW-1:0] sh_q, sh_d, act_q, act_d;
   always_comb begin
      up_d  = up_q;
      cnt_d = cnt_q == MAXC - 1'b1 ? '0 : cnt_q + 1'b1;
      if (CENTER_ALIGNED != 0) begin
         cnt_d = up_q ? (cnt_q == MAXC ? MAXC - 1'b1 : cnt_q + 1'b1) : cnt_q - 1'b1;
         up_d  = up_q ? cnt_q != MAXC : cnt_q == CW'(1);
      end
   end
   // The shadow-to-active transfer happens on the edge that brings the counter to 0.
   assign wrap   = cnt_d == '0;
   assign act_d  = wrap ? sh_q : act_q;
   assign sh_d   = duty_load ? duty : sh_q;
   assign pend_d = duty_load | (pend_q & ~wrap);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         up_q   <= 1'b1;
         ps_q   <= 1'b0;
         pend_q <= 1'b0;
         sh_q   <= '0;
         act_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         up_q   <= up_d;
         ps_q   <= wrap;
         pend_q <= pend_d;
         sh_q   <= sh_d;
         act_q  <= act_d;
      end
   end
   assign period_start = ps_q;
   assign duty_pending = pend_q;
   for (genvar i = 0; i < NUM_PHASES; i++) begin : g_ph
      logic [PW-1:0]  prod;
      logic [CW-1:0]  thr;
      logic [DCW-1:0] dc_q, dc_d;
      state_t         st_q, st_d, des;
      assign prod = PW'(act_q[i*DW +: DW]) * PW'(DUTY_SCALE);
      assign thr  = prod > PW'(MAX_COUNTER) ? MAXC : prod[CW-1:0];
      assign des  = high_z[i] ? S_OFF : thr == '0 ? S_LOW : thr == MAXC ? S_HIGH :
                    cnt_q < thr ? S_HIGH : S_LOW;
      always_comb begin
         st_d = st_q;
         dc_d = dc_q;
         if (high_z[i]) st_d = S_OFF;
         else if (st_q == S_DEAD) begin
            st_d = dc_q == '0 ? des : S_DEAD;
            dc_d = dc_q == '0 ? dc_q : dc_q - 1'b1;
         end else if (st_q == S_OFF || st_q != des) begin
            st_d = S_DEAD;
            dc_d = DCW'(DEAD_TIME - 1);
         end
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q <= S_DEAD;
            dc_q <= DCW'(DEAD_TIME - 1);
         end else begin
            st_q <= st_d;
            dc_q <= dc_d;
         end
      end
      assign pwm_high[i] = st_q == S_HIGH;
      assign pwm_low[i]  = st_q == S_LOW;
   end
endmodule
